return_address_stack_ckpt: RTL and testbench
============================================

Name: return_address_stack_ckpt

Overview:
- Parametrised return address stack (RAS) for the superscalar fetch stage, replacing the fixed 16-entry, 2-way RAS.
- Processes WAYS fetch lanes per cycle in program order, including call→return forwarding within one fetch group.
- Circular storage: overflow overwrites the oldest entry instead of stalling.
- Exports a {tos, count, top} snapshot per cycle. The stored snapshot restores the stack in one cycle on a branch mispredict.

Parameters:
- DEPTH, 16, number of stack entries; power of 2, ≥4.
- WAYS, 2, fetch lanes per cycle; 1 to 4.
- PTR_W, $clog2(DEPTH), width of the top-of-stack pointer (derived).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- clock  in  1  system clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- lane_valid  in  WAYS  lane carries a valid fetched instruction.
- is_call  in  WAYS  lane is a call (JAL); pushes call_npc.
- is_ret  in  WAYS  lane is a return (JALR); pops.
- call_npc  in  WAYS×`XLEN  return address (PC+4) of each lane.
- ret_npc  out  WAYS×`XLEN  predicted return target per lane (combinational).
- ret_valid  out  WAYS  ret_npc is meaningful (stack non-empty at that lane).
- snap_tos  out  PTR_W  current tos pointer (registered state).
- snap_cnt  out  CNT_W  current occupancy.
- snap_top  out  `XLEN  current top entry value.
- recover  in  1  restore the stack from a checkpoint (mispredict).
- rec_tos  in  PTR_W  checkpointed tos.
- rec_cnt  in  CNT_W  checkpointed count.
- rec_top  in  `XLEN  checkpointed top value.

Behaviour:
- Reset (async, reset_n=0): all entries, tos and cnt cleared to 0. ret_npc=0, ret_valid=0, snap_*=0.
- State: entry array, tos (index of the top valid entry), cnt (saturating, 0..DEPTH).
- A lane is active only if lane_valid=1.
- A lane with is_call=1 and is_ret=1 is illegal. It is treated as a call; an assertion fires in simulation.
- Lanes are evaluated sequentially within the cycle, lane 0 first. A running (tos, cnt, top) is carried lane to lane.
- Push (call, lane i):
  - tos' = tos+1 mod DEPTH; entry[tos'] = call_npc[i]; cnt' = min(cnt+1, DEPTH).
  - At DEPTH the oldest entry is silently overwritten (wrap-around).
- Pop (ret, lane i):
  - If running cnt>0: ret_npc[i] = running top, ret_valid[i]=1, tos' = tos-1 mod DEPTH, cnt' = cnt-1.
  - If cnt=0: ret_npc[i]=0, ret_valid[i]=0, state unchanged (underflow ignored).
- Intra-group forwarding: a ret in lane i after a call in lane j<i returns call_npc[j] in the same cycle, not the stale array value.
- Inactive lanes and non-ret lanes drive ret_npc=0 and ret_valid=0.
- ret_npc and ret_valid are combinational from current state plus lane inputs (zero-cycle latency). Array, tos and cnt update on the next posedge.
- Recovery:
  - recover=1: on the next posedge tos←rec_tos, cnt←rec_cnt, entry[rec_tos]←rec_top.
  - All lane pushes and pops in that cycle are discarded.
  - ret_valid is forced to 0 during a recover cycle.
- snap_* reflect registered state before this cycle's lane updates. Fetch stores them alongside each predicted branch.
- Two pushes writing the same index in one cycle (WAYS>DEPTH is disallowed, so only via wrap): the later lane wins.

Optional Feature:
- RAS_STATS_EN defined:
  - Adds outputs ovf_cnt and unf_cnt, each 16 bits, saturating.
  - ovf_cnt increments once per push executed at cnt=DEPTH.
  - unf_cnt increments once per pop attempted at cnt=0.
  - Both are suppressed in recover cycles and cleared by reset_n.
- RAS_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: reset_n=0 mid-run after 3 pushes → snap_cnt=0, snap_tos=0, ret_valid=0. A subsequent ret on lane 0 gives ret_valid=0.
- Push/pop in order: lane0 call 0x100, next cycle lane0 call 0x200, next cycle lane0 ret → ret_npc[0]=0x200. Following ret → 0x100, then snap_cnt=0.
- Intra-group forwarding: stack holds 0x100; lane0 call npc=0x300, lane1 ret in the same cycle → ret_npc[1]=0x300, snap_cnt unchanged (1) next cycle.
- Overflow wrap (DEPTH=16): push 0x1000..0x1044 (18 calls) → snap_cnt=16. 16 rets return 0x1044 down to 0x1008; the 17th ret gives ret_valid=0.
- Recovery: capture snap at 2 entries (top 0x200); push 0x500 and pop twice; assert recover with the captured values → the next ret returns 0x200 and snap_cnt=1 after it.
- Simultaneous recover and lane call 0x700 → call discarded; state equals the checkpoint exactly. With RAS_STATS_EN, ovf_cnt and unf_cnt are unchanged.

Source files
------------

// File: rtl/return_address_stack_ckpt.sv
// Return address stack with per-lane call/return handling, wrap-around overflow and one-cycle checkpoint recovery.
// Define RAS_STATS_EN to add saturating overflow/underflow event counters (ovf_cnt, unf_cnt).
`ifndef XLEN
`define XLEN 32
`endif

module return_address_stack_ckpt #(
    parameter int DEPTH = 16,
    parameter int WAYS  = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WAYS-1:0]        lane_valid,
    input  logic [WAYS-1:0]        is_call,
    input  logic [WAYS-1:0]        is_ret,
    input  logic [WAYS*`XLEN-1:0]  call_npc,
    output logic [WAYS*`XLEN-1:0]  ret_npc,
    output logic [WAYS-1:0]        ret_valid,
    output logic [PTR_W-1:0]       snap_tos,
    output logic [CNT_W-1:0]       snap_cnt,
    output logic [`XLEN-1:0]       snap_top,
    input  logic                   recover,
    input  logic [PTR_W-1:0]       rec_tos,
    input  logic [CNT_W-1:0]       rec_cnt,
    input  logic [`XLEN-1:0]       rec_top
`ifdef RAS_STATS_EN
    ,
    output logic [15:0]            ovf_cnt,
    output logic [15:0]            unf_cnt
`endif
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [`XLEN-1:0] ent_q [DEPTH];
    logic [`XLEN-1:0] ent_d [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef RAS_STATS_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] unf_q, unf_d;
    logic [2:0]  ovf_inc, unf_inc;
    logic [16:0] ovf_sum, unf_sum;
`endif

    // Lanes walk a working copy of the stack so later lanes see earlier pushes (forwarding).
    always_comb begin
        ent_d     = ent_q;
        tos_d     = tos_q;
        cnt_d     = cnt_q;
        ret_npc   = '0;
        ret_valid = '0;
`ifdef RAS_STATS_EN
        ovf_inc   = '0;
        unf_inc   = '0;
`endif
        if (recover) begin
            tos_d        = rec_tos;
            cnt_d        = rec_cnt;
            ent_d[rec_tos] = rec_top;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (lane_valid[i]) begin
                    if (is_call[i]) begin
`ifdef RAS_STATS_EN
                        if (cnt_d == FULL_CNT) begin
                            ovf_inc = ovf_inc + 3'd1;
                        end
`endif
                        tos_d        = tos_d + PTR_W'(1);
                        ent_d[tos_d] = call_npc[i*`XLEN +: `XLEN];
                        if (cnt_d != FULL_CNT) begin
                            cnt_d = cnt_d + CNT_W'(1);
                        end
                    end else if (is_ret[i]) begin
                        if (cnt_d != '0) begin
                            ret_npc[i*`XLEN +: `XLEN] = ent_d[tos_d];
                            ret_valid[i]              = 1'b1;
                            tos_d                     = tos_d - PTR_W'(1);
                            cnt_d                     = cnt_d - CNT_W'(1);
                        end else begin
`ifdef RAS_STATS_EN
                            unf_inc = unf_inc + 3'd1;
`endif
                        end
                    end
                end
            end
        end
    end

`ifdef RAS_STATS_EN
    always_comb begin
        ovf_sum = {1'b0, ovf_q} + 17'(ovf_inc);
        unf_sum = {1'b0, unf_q} + 17'(unf_inc);
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
        unf_d   = unf_sum[16] ? 16'hFFFF : unf_sum[15:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_cnt = ovf_q;
    assign unf_cnt = unf_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            tos_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    assign snap_tos = tos_q;
    assign snap_cnt = cnt_q;
    assign snap_top = ent_q[tos_q];

`ifndef SYNTHESIS
    // A lane flagged as both call and return is treated as a call, but it indicates a decode bug upstream.
    lane_call_ret_exclusive : assert property (@(posedge clock) disable iff (!reset_n)
        (lane_valid & is_call & is_ret) == '0);
`endif

endmodule

// File: tb/tb_return_address_stack_ckpt.sv
// Scoreboard bench for return_address_stack_ckpt: a queue-based stack model predicts per-lane returns and snapshots.
// Stats checks are compiled in when RAS_STATS_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module tb_return_address_stack_ckpt;

    localparam int DEPTH = 16;
    localparam int WAYS  = 2;
    localparam int PTR_W = 4;
    localparam int CNT_W = 5;
    localparam int XL    = `XLEN;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [WAYS-1:0]     lane_valid = '0;
    logic [WAYS-1:0]     is_call = '0;
    logic [WAYS-1:0]     is_ret = '0;
    logic [WAYS*XL-1:0]  call_npc = '0;
    logic [WAYS*XL-1:0]  ret_npc;
    logic [WAYS-1:0]     ret_valid;
    logic [PTR_W-1:0]    snap_tos;
    logic [CNT_W-1:0]    snap_cnt;
    logic [XL-1:0]       snap_top;
    logic                recover = 1'b0;
    logic [PTR_W-1:0]    rec_tos = '0;
    logic [CNT_W-1:0]    rec_cnt = '0;
    logic [XL-1:0]       rec_top = '0;
`ifdef RAS_STATS_EN
    logic [15:0]         ovf_cnt;
    logic [15:0]         unf_cnt;
`endif

    return_address_stack_ckpt #(.DEPTH(DEPTH), .WAYS(WAYS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .lane_valid (lane_valid),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .call_npc   (call_npc),
        .ret_npc    (ret_npc),
        .ret_valid  (ret_valid),
        .snap_tos   (snap_tos),
        .snap_cnt   (snap_cnt),
        .snap_top   (snap_top),
        .recover    (recover),
        .rec_tos    (rec_tos),
        .rec_cnt    (rec_cnt),
        .rec_top    (rec_top)
`ifdef RAS_STATS_EN
        ,
        .ovf_cnt    (ovf_cnt),
        .unf_cnt    (unf_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          probe;
        logic [63:0] exp;
    } sb_item_t;

    int            checks = 0;
    int            errors = 0;
    sb_item_t      sb_q[$];
    logic [XL-1:0] m_stack[$];
    logic [XL-1:0] ck_stack[$];
    int            m_tos = 0;
    int            ck_tos = 0;
    int            m_ovf = 0;
    int            m_unf = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] observe(input int probe);
        case (probe)
            0: return 64'(ret_valid[0]);
            1: return 64'(ret_npc[XL-1:0]);
            2: return 64'(ret_valid[1]);
            3: return 64'(ret_npc[2*XL-1:XL]);
            4: return 64'(snap_cnt);
            5: return 64'(snap_tos);
            6: return 64'(snap_top);
`ifdef RAS_STATS_EN
            7: return 64'(ovf_cnt);
            8: return 64'(unf_cnt);
`endif
            default: return '1;
        endcase
    endfunction

    task automatic expectVal(input string tag, input int probe, input logic [63:0] exp);
        sb_item_t it;
        it.tag   = tag;
        it.probe = probe;
        it.exp   = exp;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checkOutput(it.tag, observe(it.probe), it.exp);
        end
    endtask

    task automatic expectSnap(input string name);
        expectVal({name, " snap_cnt"}, 4, 64'(m_stack.size()));
        expectVal({name, " snap_tos"}, 5, 64'(m_tos));
        if (m_stack.size() > 0) begin
            expectVal({name, " snap_top"}, 6, 64'(m_stack[$]));
        end
`ifdef RAS_STATS_EN
        expectVal({name, " ovf_cnt"}, 7, 64'(m_ovf));
        expectVal({name, " unf_cnt"}, 8, 64'(m_unf));
`endif
    endtask

    // Drives one fetch group, checks the combinational returns, then checks the registered snapshot after the edge.
    task automatic applyStimulus(input string name, input logic [1:0] lv, input logic [1:0] cl,
                                 input logic [1:0] rt, input logic [XL-1:0] n0, input logic [XL-1:0] n1,
                                 input logic rec);
        logic [XL-1:0] npc;
        logic [XL-1:0] r;
        logic          v;
        lane_valid = lv;
        is_call    = cl;
        is_ret     = rt;
        call_npc   = {n1, n0};
        recover    = rec;
        if (rec) begin
            m_stack = ck_stack;
            m_tos   = ck_tos;
            for (int i = 0; i < WAYS; i++) begin
                expectVal($sformatf("%s rv%0d", name, i), 2*i, 64'(0));
                expectVal($sformatf("%s rn%0d", name, i), 2*i+1, 64'(0));
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                npc = (i == 0) ? n0 : n1;
                r   = '0;
                v   = 1'b0;
                if (lv[i] && cl[i]) begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf++;
                    end
                    m_stack.push_back(npc);
                    m_tos = (m_tos + 1) % DEPTH;
                end else if (lv[i] && rt[i]) begin
                    if (m_stack.size() > 0) begin
                        r     = m_stack.pop_back();
                        v     = 1'b1;
                        m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    end else begin
                        m_unf++;
                    end
                end
                expectVal($sformatf("%s rv%0d", name, i), 2*i, 64'(v));
                expectVal($sformatf("%s rn%0d", name, i), 2*i+1, 64'(r));
            end
        end
        #1;
        drain();
        @(posedge clock);
        #1;
        lane_valid = '0;
        is_call    = '0;
        is_ret     = '0;
        call_npc   = '0;
        recover    = 1'b0;
        expectSnap(name);
        drain();
    endtask

    task automatic captureCheckpoint();
        rec_tos  = snap_tos;
        rec_cnt  = snap_cnt;
        rec_top  = snap_top;
        ck_stack = m_stack;
        ck_tos   = m_tos;
    endtask

    initial begin
        #3;
        expectVal("reset snap_cnt", 4, 64'(0));
        expectVal("reset snap_tos", 5, 64'(0));
        expectVal("reset snap_top", 6, 64'(0));
        expectVal("reset rv0", 0, 64'(0));
        drain();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Mid-run reset after three pushes.
        applyStimulus("pre-reset a", 2'b01, 2'b01, 2'b00, 32'h10, 32'h0, 1'b0);
        applyStimulus("pre-reset b", 2'b01, 2'b01, 2'b00, 32'h20, 32'h0, 1'b0);
        applyStimulus("pre-reset c", 2'b01, 2'b01, 2'b00, 32'h30, 32'h0, 1'b0);
        #2;
        reset_n = 1'b0;
        m_stack.delete();
        m_tos = 0;
        m_ovf = 0;
        m_unf = 0;
        #1;
        expectSnap("midreset");
        expectVal("midreset rv0", 0, 64'(0));
        drain();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus("ret after reset", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);

        // In-order push and pop.
        applyStimulus("push 100", 2'b01, 2'b01, 2'b00, 32'h100, 32'h0, 1'b0);
        applyStimulus("push 200", 2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b0);
        applyStimulus("pop 200", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
        applyStimulus("pop 100", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);

        // Call and return in the same group forward the new address.
        applyStimulus("fwd base", 2'b01, 2'b01, 2'b00, 32'h100, 32'h0, 1'b0);
        applyStimulus("fwd group", 2'b11, 2'b01, 2'b10, 32'h300, 32'h0, 1'b0);
        applyStimulus("dual push", 2'b11, 2'b11, 2'b00, 32'hA00, 32'hB00, 1'b0);
        applyStimulus("dual pop", 2'b11, 2'b00, 2'b11, 32'h0, 32'h0, 1'b0);
        applyStimulus("drain 100", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
        applyStimulus("underflow", 2'b11, 2'b00, 2'b11, 32'h0, 32'h0, 1'b0);

        // Overflow wraps and drops the oldest entries.
        for (int k = 0; k < 18; k++) begin
            applyStimulus($sformatf("ovf push %0d", k), 2'b01, 2'b01, 2'b00, 32'h1000 + 32'(4*k), 32'h0, 1'b0);
        end
        for (int k = 0; k < 17; k++) begin
            applyStimulus($sformatf("ovf pop %0d", k), 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
        end

        // Checkpoint recovery.
        applyStimulus("rec push 100", 2'b01, 2'b01, 2'b00, 32'h100, 32'h0, 1'b0);
        applyStimulus("rec push 200", 2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 1'b0);
        captureCheckpoint();
        applyStimulus("rec push 500", 2'b01, 2'b01, 2'b00, 32'h500, 32'h0, 1'b0);
        applyStimulus("rec pop 500", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
        applyStimulus("rec pop 200", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
        applyStimulus("recover", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b1);
        applyStimulus("post-rec pop", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);

        // Recover while a call and a return are presented: both are discarded.
        captureCheckpoint();
        applyStimulus("rec2 push 600", 2'b01, 2'b01, 2'b00, 32'h600, 32'h0, 1'b0);
        applyStimulus("recover+call", 2'b11, 2'b01, 2'b10, 32'h700, 32'h0, 1'b1);
        checkOutput("ckpt exact cnt", 64'(snap_cnt), 64'(1));
        checkOutput("ckpt exact top", 64'(snap_top), 64'h100);
        applyStimulus("rec2 pop 100", 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
